// File: rtl/ladybird_fetch_queue.sv
// ladybird_fetch_queue: instruction prefetch queue between the MMU instruction
// port and decode. Issues sequential fetch addresses, tags each returned
// instruction with its PC, buffers up to DEPTH entries, and on a redirect
// flushes everything while counting responses still owed by the MMU so they
// can be discarded when they arrive.
module ladybird_fetch_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   input  logic            pc_ready,
   input  logic [XLEN-1:0] inst,
   input  logic            inst_valid,
   output logic            o_valid,
   input  logic            o_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_inst,
   output logic            busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic            running_reg;
   logic [XLEN-1:0] fetch_pc_reg;
   logic [PW-1:0]   head_reg;
   logic [PW-1:0]   fill_reg;
   logic [PW-1:0]   tail_reg;
   logic [CW-1:0]   alloc_cnt_reg;
   logic [CW-1:0]   drop_cnt_reg;

   // Flattened views of the per-entry storage built in the generate loop.
   logic [XLEN-1:0]  entry_pc   [DEPTH];
   logic [XLEN-1:0]  entry_inst [DEPTH];
   logic [DEPTH-1:0] filled;

   logic          issue;
   logic          pop;
   logic          resp_write;
   logic          resp_drop;
   logic [CW:0]   credit_used;
   logic [CW-1:0] filled_cnt;
   logic [CW-1:0] unfilled_cnt;
   logic [CW-1:0] drop_cnt_next;

   // Credit check, handshakes and response routing; a redirect masks everything.
   always_comb begin
      credit_used = {1'b0, alloc_cnt_reg} + {1'b0, drop_cnt_reg};
      pc_valid    = running_reg & ~redirect_valid & (credit_used < (CW+1)'(DEPTH));
      issue       = pc_valid & pc_ready;
      o_valid     = filled[head_reg] & ~redirect_valid;
      pop         = o_valid & o_ready;
      resp_drop   = inst_valid & (drop_cnt_reg != '0);
      resp_write  = inst_valid & (drop_cnt_reg == '0) & ~redirect_valid;
   end

   // Responses still owed after a flush: old debt plus allocated-but-unfilled
   // entries, minus a response that lands in the redirect cycle itself.
   always_comb begin
      filled_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         filled_cnt = filled_cnt + CW'(filled[i]);
      end
      unfilled_cnt  = alloc_cnt_reg - filled_cnt;
      drop_cnt_next = drop_cnt_reg + unfilled_cnt - CW'(inst_valid);
   end

   // Run flag, fetch address, ring pointers and credit counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         running_reg   <= 1'b0;
         fetch_pc_reg  <= '0;
         head_reg      <= '0;
         fill_reg      <= '0;
         tail_reg      <= '0;
         alloc_cnt_reg <= '0;
         drop_cnt_reg  <= '0;
      end else if (redirect_valid) begin
         running_reg   <= 1'b1;
         fetch_pc_reg  <= redirect_pc;
         head_reg      <= '0;
         fill_reg      <= '0;
         tail_reg      <= '0;
         alloc_cnt_reg <= '0;
         drop_cnt_reg  <= drop_cnt_next;
      end else begin
         if (issue) begin
            tail_reg     <= tail_reg + PW'(1);
            fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
         end
         if (resp_write) begin
            fill_reg <= fill_reg + PW'(1);
         end
         if (pop) begin
            head_reg <= head_reg + PW'(1);
         end
         if (resp_drop) begin
            drop_cnt_reg <= drop_cnt_reg - CW'(1);
         end
         alloc_cnt_reg <= alloc_cnt_reg + CW'(issue) - CW'(pop);
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [XLEN-1:0] pc_reg;
         logic [XLEN-1:0] inst_reg;
         logic            filled_reg;

         // Entry gi: takes its PC on issue, its instruction on response, and
         // is released on pop or flush.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pc_reg     <= '0;
               inst_reg   <= '0;
               filled_reg <= 1'b0;
            end else if (redirect_valid) begin
               filled_reg <= 1'b0;
            end else begin
               if (issue && (tail_reg == PW'(gi))) begin
                  pc_reg     <= fetch_pc_reg;
                  filled_reg <= 1'b0;
               end
               if (resp_write && (fill_reg == PW'(gi))) begin
                  inst_reg   <= inst;
                  filled_reg <= 1'b1;
               end
               if (pop && (head_reg == PW'(gi))) begin
                  filled_reg <= 1'b0;
               end
            end
         end

         assign entry_pc[gi]   = pc_reg;
         assign entry_inst[gi] = inst_reg;
         assign filled[gi]     = filled_reg;
      end
   endgenerate

   assign pc     = fetch_pc_reg;
   assign o_pc   = entry_pc[head_reg];
   assign o_inst = entry_inst[head_reg];
   assign busy   = running_reg | (alloc_cnt_reg != '0) | (drop_cnt_reg != '0);

endmodule
